// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver with a small receive FIFO behind a valid/ready
// handshake; flags framing errors (stop bit low) and overruns (FIFO full).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk2,
  input  logic                 reset,
  input  logic                 RXdataIn,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic                 sync_p0, sync_p1;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic                 empty, full, pop, push_req, push_ok, stop_done;

  // Stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= RXdataIn;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s      = sync_p1;
  assign stop_done = (state == STOP) && (cnt == BIT_LAST);
  assign push_req  = stop_done && rx_s;

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (idx == IDX_W'(i)) shreg[i] <= rx_s;
            end
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Held-low line must return high before a new start bit is honoured
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign dataOut  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk2) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= shreg;
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      frame_err <= stop_done && !rx_s;
      overrun   <= push_req && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames push expected bytes, a
// negedge monitor pops and compares on every accepted handshake.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic       RXdataIn = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] dataOut;
  logic       rx_valid, frame_err, overrun, busy;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk2(clk2), .reset(reset), .RXdataIn(RXdataIn), .rx_ready(rx_ready),
    .dataOut(dataOut), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: evaluates the handshake in the middle of each cycle
  always @(negedge clk2) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(dataOut), 32'h1FF);
        end else begin
          check("rx_byte", 32'(dataOut), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk2);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    RXdataIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXdataIn = b[i];
      tick(CPB);
    end
    RXdataIn = stopv;
    tick(CPB);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(dataOut), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    tick(3);
    reset = 1'b0;
    tick(4);

    // Single frame with latency and one-cycle valid pulse
    rx_ready = 1'b1;
    exp_q.push_back(8'h95);
    fork
      send_frame(8'h95, 1'b1);
      begin
        tick(154);
        check("t1_valid_early", 32'(rx_valid), 0);
        tick(1);
        check("t1_valid_rise", 32'(rx_valid), 1);
        tick(1);
        check("t1_valid_pulse", 32'(rx_valid), 0);
      end
    join
    check("t1_busy", 32'(busy), 0);
    check("t1_pops", pop_cnt, 1);
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovr", ov_cnt, 0);

    // Glitch rejection
    RXdataIn = 1'b0;
    tick(4);
    RXdataIn = 1'b1;
    tick(20);
    check("t2_busy", 32'(busy), 0);
    check("t2_pops", pop_cnt, 1);
    exp_q.push_back(8'hB9);
    send_frame(8'hB9, 1'b1);
    wait_drain("t2_drain");
    check("t2_ferr", fe_cnt, 0);

    // Framing error and break hold
    send_frame(8'hC3, 1'b0);
    tick(64);
    check("t3_break_busy", 32'(busy), 1);
    RXdataIn = 1'b1;
    tick(4);
    check("t3_idle", 32'(busy), 0);
    check("t3_ferr", fe_cnt, 1);
    check("t3_pops", pop_cnt, 2);
    exp_q.push_back(8'hCC);
    send_frame(8'hCC, 1'b1);
    wait_drain("t3_drain");

    // Overrun on the fifth frame
    rx_ready = 1'b0;
    exp_q.push_back(8'h95); send_frame(8'h95, 1'b1);
    exp_q.push_back(8'hB9); send_frame(8'hB9, 1'b1);
    exp_q.push_back(8'hC3); send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hCC); send_frame(8'hCC, 1'b1);
    send_frame(8'h5A, 1'b1);
    tick(2);
    check("t4_ovr", ov_cnt, 1);
    check("t4_valid", 32'(rx_valid), 1);
    check("t4_head", 32'(dataOut), 32'h95);
    rx_ready = 1'b1;
    wait_drain("t4_drain");
    tick(2);
    check("t4_empty", 32'(rx_valid), 0);

    // Push and pop in the same cycle while full
    rx_ready = 1'b0;
    exp_q.push_back(8'h95); send_frame(8'h95, 1'b1);
    exp_q.push_back(8'hB9); send_frame(8'hB9, 1'b1);
    exp_q.push_back(8'hC3); send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hCC); send_frame(8'hCC, 1'b1);
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(154);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(2);
    check("t5_ovr", ov_cnt, 1);
    check("t5_head", 32'(dataOut), 32'hB9);
    rx_ready = 1'b1;
    wait_drain("t5_drain");
    tick(2);
    check("t5_empty", 32'(rx_valid), 0);

    // Reset mid-frame discards partial frame and FIFO contents
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(2);
    check("t6_prefill", 32'(rx_valid), 1);
    RXdataIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RXdataIn = 1'(8'hB9 >> i);
      tick(CPB);
    end
    RXdataIn = 1'b1;
    tick(8);
    check("t6_busy_before", 32'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    #2;
    check("t6_rst_valid", 32'(rx_valid), 0);
    check("t6_rst_data", 32'(dataOut), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ferr", 32'(frame_err), 0);
    check("t6_rst_ovr", 32'(overrun), 0);
    tick(3);
    reset = 1'b0;
    tick(CPB * 2);
    check("t6_idle_after", 32'(rx_valid), 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("t6_drain");
    tick(4);
    check("t6_empty", 32'(rx_valid), 0);
    check("final_ferr", fe_cnt, 1);
    check("final_ovr", ov_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
